// File: rtl/board_input_debounce_pkg.sv
// ---------------------------------------------------------------------------
// board_input_debounce_pkg
//
// Shared constants and helpers for the board input debouncer.
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms settle time at the 8 MHz PLL clock
//   SWITCH_CHANNELS         : Basys3 slide switch count
//   BUTTON_CHANNELS         : Basys3 push-button count
//   counterWidth()          : width of the per-channel settle counter
// ---------------------------------------------------------------------------
package board_input_debounce_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 80000;
  localparam int unsigned SWITCH_CHANNELS         = 16;
  localparam int unsigned BUTTON_CHANNELS         = 5;

  // Counter must hold values up to cycles-1; a 1-bit counter is the floor
  // so the smallest legal setting (2) still gets a real register.
  function automatic int unsigned counterWidth(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/board_input_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//
// One input bit: 2-flop synchroniser, settle counter, debounced level and
// registered edge pulses.
//   clk, reset       : clock, asynchronous active-high reset
//   raw_in           : unsynchronised board input bit
//   stable           : debounced level
//   rise, fall       : one-cycle pulses on accepted 0->1 / 1->0
//   rise_next        : combinational "rise will assert on the next edge"
//   fall_next        : combinational "fall will assert on the next edge"
// ---------------------------------------------------------------------------
module debounce_channel
  import board_input_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic rise_next,
  output logic fall_next
);

  localparam int unsigned CW = counterWidth(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;
  logic          w_mismatch;
  logic          w_accept;

  // A new level is accepted only after it has disagreed with the current
  // stable level for DEBOUNCE_CYCLES consecutive synchronised samples.
  assign w_mismatch = r_s2 ^ r_stable;
  assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);
  assign rise_next  = w_accept & r_s2;
  assign fall_next  = w_accept & ~r_s2;

  // Synchroniser, settle counter, stable level and edge pulses. Any
  // matching sample restarts the count, so glitches never accumulate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1     <= RESET_VALUE;
      r_s2     <= RESET_VALUE;
      r_stable <= RESET_VALUE;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_s1   <= raw_in;
      r_s2   <= r_s1;
      r_rise <= rise_next;
      r_fall <= fall_next;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign stable = r_stable;
  assign rise   = r_rise;
  assign fall   = r_fall;

endmodule

// File: rtl/board_input_debounce.sv
// ---------------------------------------------------------------------------
// board_input_debounce
//
// Debounces WIDTH board inputs independently and reports changes.
//   clk, reset : 8 MHz system clock, asynchronous active-high reset
//   raw_in     : unsynchronised board inputs
//   stable     : debounced levels
//   rise, fall : one-cycle pulses per channel on accepted edges
//   evt_valid  : at least one channel changed since the last acknowledge
//   evt_mask   : sticky OR of rise|fall since the last acknowledge
//   evt_ack    : consumer acknowledge, honoured only while evt_valid is high
//
// Build option: define BOARD_INPUT_EVENT_LATCH_EN to include the event
// latch and ack handshake; otherwise evt_valid/evt_mask are tied low and
// evt_ack is ignored.
// ---------------------------------------------------------------------------
module board_input_debounce
  import board_input_debounce_pkg::*;
#(
  parameter int unsigned      WIDTH           = SWITCH_CHANNELS,
  parameter int unsigned      DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_mask,
  input  logic             evt_ack
);

  logic [WIDTH-1:0] w_riseNext;
  logic [WIDTH-1:0] w_fallNext;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (RESET_VALUE[g])
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .raw_in    (raw_in[g]),
      .stable    (stable[g]),
      .rise      (rise[g]),
      .fall      (fall[g]),
      .rise_next (w_riseNext[g]),
      .fall_next (w_fallNext[g])
    );
  end

`ifdef BOARD_INPUT_EVENT_LATCH_EN
  logic [WIDTH-1:0] r_evtMask;
  logic             r_evtValid;
  logic             w_ackFire;
  logic [WIDTH-1:0] w_maskNext;

  // The ack clears the old mask but changes accepted on the same edge are
  // ORed in afterwards, so they survive the acknowledge.
  assign w_ackFire  = evt_ack & r_evtValid;
  assign w_maskNext = (w_ackFire ? '0 : r_evtMask) | w_riseNext | w_fallNext;

  // Valid is computed from the next mask so it tracks the mask edge-for-edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_evtMask  <= '0;
      r_evtValid <= 1'b0;
    end else begin
      r_evtMask  <= w_maskNext;
      r_evtValid <= |w_maskNext;
    end
  end

  assign evt_mask  = r_evtMask;
  assign evt_valid = r_evtValid;
`else
  logic w_unusedLatchInputs;

  assign w_unusedLatchInputs = evt_ack | (|w_riseNext) | (|w_fallNext);
  assign evt_mask  = '0;
  assign evt_valid = 1'b0;
`endif

endmodule

// File: tb/tb_board_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_board_input_debounce
//
// Directed bench with DEBOUNCE_CYCLES=4. A second instance with
// RESET_VALUE=16'hFFFF covers reset-value loading and mid-count reset.
// ---------------------------------------------------------------------------
module tb_board_input_debounce;

`ifdef BOARD_INPUT_EVENT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] rawIn;
  logic [15:0] stable;
  logic [15:0] rise;
  logic [15:0] fall;
  logic        evtValid;
  logic [15:0] evtMask;
  logic        evtAck;

  logic        reset2;
  logic [15:0] rawIn2;
  logic [15:0] stable2;
  logic [15:0] rise2;
  logic [15:0] fall2;
  logic        evtValid2;
  logic [15:0] evtMask2;
  logic        evtAck2;

  int nChecks;
  int nPassed;

  board_input_debounce #(
    .WIDTH           (16),
    .DEBOUNCE_CYCLES (4),
    .RESET_VALUE     (16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (rawIn),
    .stable    (stable),
    .rise      (rise),
    .fall      (fall),
    .evt_valid (evtValid),
    .evt_mask  (evtMask),
    .evt_ack   (evtAck)
  );

  board_input_debounce #(
    .WIDTH           (16),
    .DEBOUNCE_CYCLES (4),
    .RESET_VALUE     (16'hFFFF)
  ) dutHigh (
    .clk       (clk),
    .reset     (reset2),
    .raw_in    (rawIn2),
    .stable    (stable2),
    .rise      (rise2),
    .fall      (fall2),
    .evt_valid (evtValid2),
    .evt_mask  (evtMask2),
    .evt_ack   (evtAck2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ackPulse();
    evtAck = 1'b1;
    tick();
    evtAck = 1'b0;
  endtask

  task automatic test_reset();
    nChecks++;
    if (stable !== 16'h0000 || rise !== 16'h0000 || fall !== 16'h0000) begin
      $display("[TB] FAIL reset_outputs: stable=%h rise=%h fall=%h, required 0000/0000/0000", stable, rise, fall);
    end else nPassed++;
    nChecks++;
    if (evtValid !== 1'b0 || evtMask !== 16'h0000) begin
      $display("[TB] FAIL reset_event: valid=%b mask=%h, required 0/0000", evtValid, evtMask);
    end else nPassed++;
    nChecks++;
    if (stable2 !== 16'hFFFF || rise2 !== 16'h0000 || fall2 !== 16'h0000) begin
      $display("[TB] FAIL reset_value_ffff: stable=%h rise=%h fall=%h, required ffff/0000/0000", stable2, rise2, fall2);
    end else nPassed++;
  endtask

  task automatic test_single_rise();
    logic [15:0] early;
    early = '0;
    rawIn[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      early = early | stable | rise;
    end
    nChecks++;
    if (early !== 16'h0000) begin
      $display("[TB] FAIL rise_too_early: saw %h before edge 6, required 0000", early);
    end else nPassed++;
    tick();
    nChecks++;
    if (stable !== 16'h0001 || rise !== 16'h0001 || fall !== 16'h0000) begin
      $display("[TB] FAIL rise_edge6: stable=%h rise=%h fall=%h, required 0001/0001/0000", stable, rise, fall);
    end else nPassed++;
    nChecks++;
    if (evtValid !== LATCH || evtMask !== (LATCH ? 16'h0001 : 16'h0000)) begin
      $display("[TB] FAIL rise_event: valid=%b mask=%h, required %b/%h", evtValid, evtMask, LATCH, (LATCH ? 16'h0001 : 16'h0000));
    end else nPassed++;
    tick();
    nChecks++;
    if (rise !== 16'h0000 || stable !== 16'h0001) begin
      $display("[TB] FAIL rise_one_cycle: rise=%h stable=%h, required 0000/0001", rise, stable);
    end else nPassed++;
    ackPulse();
    nChecks++;
    if (evtValid !== 1'b0 || evtMask !== 16'h0000) begin
      $display("[TB] FAIL ack_clear: valid=%b mask=%h, required 0/0000", evtValid, evtMask);
    end else nPassed++;
  endtask

  task automatic test_glitch();
    logic [15:0] seen;
    logic        seenValid;
    seen = '0;
    seenValid = 1'b0;
    rawIn[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | rise | fall;
      seenValid = seenValid | evtValid;
    end
    rawIn[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | rise | fall;
      seenValid = seenValid | evtValid;
    end
    nChecks++;
    if (stable !== 16'h0001 || seen !== 16'h0000 || seenValid !== 1'b0) begin
      $display("[TB] FAIL glitch_reject: stable=%h pulses=%h valid=%b, required 0001/0000/0", stable, seen, seenValid);
    end else nPassed++;
  endtask

  task automatic test_simultaneous();
    rawIn = 16'h8003;
    for (int i = 0; i < 6; i++) tick();
    nChecks++;
    if (rise !== 16'h8002 || fall !== 16'h0000) begin
      $display("[TB] FAIL simul_rise: rise=%h fall=%h, required 8002/0000", rise, fall);
    end else nPassed++;
    nChecks++;
    if (evtValid !== LATCH || evtMask !== (LATCH ? 16'h8002 : 16'h0000)) begin
      $display("[TB] FAIL simul_mask: valid=%b mask=%h, required %b/%h", evtValid, evtMask, LATCH, (LATCH ? 16'h8002 : 16'h0000));
    end else nPassed++;
    tick();
    nChecks++;
    if (rise !== 16'h0000 || stable !== 16'h8003) begin
      $display("[TB] FAIL simul_after: rise=%h stable=%h, required 0000/8003", rise, stable);
    end else nPassed++;
    ackPulse();
    nChecks++;
    if (evtValid !== 1'b0 || evtMask !== 16'h0000) begin
      $display("[TB] FAIL simul_ack: valid=%b mask=%h, required 0/0000", evtValid, evtMask);
    end else nPassed++;
  endtask

  task automatic test_back_to_back_ack();
    rawIn[2] = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    nChecks++;
    if (stable !== 16'h8007) begin
      $display("[TB] FAIL bit2_set: stable=%h, required 8007", stable);
    end else nPassed++;
    ackPulse();
    rawIn[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    nChecks++;
    if (fall !== 16'h0001 || evtMask !== (LATCH ? 16'h0001 : 16'h0000)) begin
      $display("[TB] FAIL bit0_fall: fall=%h mask=%h, required 0001/%h", fall, evtMask, (LATCH ? 16'h0001 : 16'h0000));
    end else nPassed++;
    tick();
    // Acknowledge lands on the same edge that accepts the bit 2 fall.
    rawIn[2] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    evtAck = 1'b1;
    tick();
    evtAck = 1'b0;
    nChecks++;
    if (fall !== 16'h0004 || stable !== 16'h8002) begin
      $display("[TB] FAIL collide_fall: fall=%h stable=%h, required 0004/8002", fall, stable);
    end else nPassed++;
    nChecks++;
    if (evtValid !== LATCH || evtMask !== (LATCH ? 16'h0004 : 16'h0000)) begin
      $display("[TB] FAIL collide_mask: valid=%b mask=%h, required %b/%h", evtValid, evtMask, LATCH, (LATCH ? 16'h0004 : 16'h0000));
    end else nPassed++;
    tick();
    nChecks++;
    if (fall !== 16'h0000 || evtMask !== (LATCH ? 16'h0004 : 16'h0000)) begin
      $display("[TB] FAIL collide_hold: fall=%h mask=%h, required 0000/%h", fall, evtMask, (LATCH ? 16'h0004 : 16'h0000));
    end else nPassed++;
    ackPulse();
  endtask

  task automatic test_raw5();
    rawIn[5] = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    nChecks++;
    if (rise !== 16'h0020 || evtMask !== (LATCH ? 16'h0020 : 16'h0000) || evtValid !== LATCH) begin
      $display("[TB] FAIL raw5_rise: rise=%h mask=%h valid=%b, required 0020/%h/%b", rise, evtMask, evtValid, (LATCH ? 16'h0020 : 16'h0000), LATCH);
    end else nPassed++;
    tick();
    nChecks++;
    if (rise !== 16'h0000 || stable !== 16'h8022) begin
      $display("[TB] FAIL raw5_after: rise=%h stable=%h, required 0000/8022", rise, stable);
    end else nPassed++;
    ackPulse();
  endtask

  task automatic test_reset_mid_count();
    logic [15:0] seen;
    logic        seenValid;
    seen = '0;
    seenValid = 1'b0;
    rawIn2 = 16'h0000;
    for (int i = 0; i < 4; i++) tick();
    nChecks++;
    if (stable2 !== 16'hFFFF) begin
      $display("[TB] FAIL midcount_hold: stable=%h, required ffff", stable2);
    end else nPassed++;
    reset2 = 1'b1;
    rawIn2 = 16'hFFFF;
    tick();
    tick();
    reset2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | rise2 | fall2;
      seenValid = seenValid | evtValid2;
    end
    nChecks++;
    if (stable2 !== 16'hFFFF || seen !== 16'h0000 || seenValid !== 1'b0) begin
      $display("[TB] FAIL midcount_reset: stable=%h pulses=%h valid=%b, required ffff/0000/0", stable2, seen, seenValid);
    end else nPassed++;
  endtask

  initial begin
    nChecks = 0;
    nPassed = 0;
    reset   = 1'b1;
    reset2  = 1'b1;
    rawIn   = 16'h0000;
    rawIn2  = 16'hFFFF;
    evtAck  = 1'b0;
    evtAck2 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset  = 1'b0;
    reset2 = 1'b0;
    tick();
    test_reset();
    test_single_rise();
    test_glitch();
    test_simultaneous();
    test_back_to_back_ack();
    test_raw5();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
